spawn_ctrl: RTL

Sequences the spawn of a new tetromino into the top of the playfield grid. On a spawn request it reads grid rows 0 and 1 through the grid RAM read port and scans left-to-right for the first column where the piece's two-row footprint lands on empty cells. It then writes the coloured footprint back, reports the anchor row/column to the piece-motion logic, or raises a sticky game-over when no column fits. It sits between the game FSM (requester) and the grid RAM, and is the only block that drives the grid write port during spawn.

---
 rtl/spawn_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spawn_ctrl.sv
// spawn_ctrl: places a new tetromino into grid rows 0/1.
// Scans left-to-right for the first fitting column, or flags game over.
module spawn_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic [2:0]  spawn_color,
    input  logic [3:0]  top_mask,
    input  logic [3:0]  bot_mask,
    input  logic        clear_go,
    output logic        rd_en,
    output logic [4:0]  rd_row,
    input  logic [29:0] rd_data,
    output logic        wr_en,
    output logic [4:0]  wr_row,
    output logic [29:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic        game_over,
    output logic [4:0]  row_ref,
    output logic [3:0]  col_ref
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_CAP1 = 3'd2;
    localparam logic [2:0] S_SCAN = 3'd3;
    localparam logic [2:0] S_WR0  = 3'd4;
    localparam logic [2:0] S_WR1  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [2:0]  color_q, color_d;
    logic [3:0]  top_q, top_d;
    logic [3:0]  bot_q, bot_d;
    logic [29:0] row0_q, row0_d;
    logic [29:0] row1_q, row1_d;
    logic [3:0]  c_q, c_d;
    logic        ok_q, ok_d;
    logic        go_q, go_d;
    logic [3:0]  col_q, col_d;
    logic [4:0]  rref_q, rref_d;

    logic [9:0]  occ0, occ1;
    logic [9:0]  foot_t, foot_b;
    logic [29:0] wdat0, wdat1;
    logic [2:0]  w;
    logic [3:0]  last;
    logic        fit;
    logic        legal;

    // Occupancy, footprint at column c, and merged write-back rows
    always_comb begin
        occ0  = '0;
        occ1  = '0;
        wdat0 = '0;
        wdat1 = '0;
        foot_t = {6'b0, top_q} << c_q;
        foot_b = {6'b0, bot_q} << c_q;
        for (int k = 0; k < 10; k++) begin
            occ0[k] = |row0_q[3*k +: 3];
            occ1[k] = |row1_q[3*k +: 3];
            wdat0[3*k +: 3] = foot_t[k] ? color_q
                                        : row0_q[3*k +: 3];
            wdat1[3*k +: 3] = foot_b[k] ? color_q
                                        : row1_q[3*k +: 3];
        end
        fit = ~|(foot_t & occ0) & ~|(foot_b & occ1);
    end

    // Piece width from highest set footprint bit; last legal anchor
    always_comb begin
        w = '0;
        for (int j = 0; j < 4; j++) begin
            if (top_q[j] | bot_q[j]) begin
                w = 3'(j) + 3'd1;
            end
        end
        last  = 4'd10 - {1'b0, w};
        legal = (spawn_color != 3'd0) &&
                ((top_mask | bot_mask) != 4'd0);
    end

    // Next-state logic and read/write port strobes
    always_comb begin
        state_d = state_q;
        color_d = color_q;
        top_d   = top_q;
        bot_d   = bot_q;
        row0_d  = row0_q;
        row1_d  = row1_q;
        c_d     = c_q;
        ok_d    = ok_q;
        go_d    = go_q;
        col_d   = col_q;
        rref_d  = rref_q;
        rd_en   = 1'b0;
        rd_row  = 5'd0;
        wr_en   = 1'b0;
        wr_row  = 5'd0;
        wr_data = '0;
        case (state_q)
            S_IDLE: begin
                if (clear_go) begin
                    go_d = 1'b0;
                end else if (spawn_req && !go_q) begin
                    color_d = spawn_color;
                    top_d   = top_mask;
                    bot_d   = bot_mask;
                    if (legal) begin
                        rd_en   = 1'b1;
                        rd_row  = 5'd0;
                        state_d = S_RD1;
                    end else begin
                        ok_d    = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RD1: begin
                row0_d  = rd_data;
                rd_en   = 1'b1;
                rd_row  = 5'd1;
                state_d = S_CAP1;
            end
            S_CAP1: begin
                row1_d  = rd_data;
                c_d     = 4'd0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (fit) begin
                    state_d = S_WR0;
                end else if (c_q == last) begin
                    ok_d    = 1'b0;
                    go_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            S_WR0: begin
                wr_en   = 1'b1;
                wr_row  = 5'd0;
                wr_data = wdat0;
                state_d = S_WR1;
            end
            S_WR1: begin
                wr_en   = 1'b1;
                wr_row  = 5'd1;
                wr_data = wdat1;
                ok_d    = 1'b1;
                col_d   = c_q;
                rref_d  = 5'd1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any spawn in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            color_q <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            row0_q  <= '0;
            row1_q  <= '0;
            c_q     <= '0;
            ok_q    <= 1'b0;
            go_q    <= 1'b0;
            col_q   <= '0;
            rref_q  <= '0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            c_q     <= c_d;
            ok_q    <= ok_d;
            go_q    <= go_d;
            col_q   <= col_d;
            rref_q  <= rref_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ok        = ok_q;
    assign game_over = go_q;
    assign row_ref   = rref_q;
    assign col_ref   = col_q;

endmodule
